// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: nominal wire timing, cycle conversion, pixel width
// and the receive decoder state encoding.
package ws2812_pkg;

   localparam int unsigned T0H_NS    = 400;
   localparam int unsigned T1H_NS    = 800;
   localparam int unsigned TBIT_NS   = 1250;
   localparam int unsigned TRESET_NS = 50000;

   localparam int PIX_W = 24;

   typedef enum logic [1:0] {SYNC, LOW, HIGH} dec_state_e;

   // Round up so a derived width is never shorter than the nominal time.
   function automatic int unsigned cycles(input int unsigned ns, input int unsigned clk_hz);
      longint unsigned prod;
      prod = longint'(ns) * longint'(clk_hz);
      return int'((prod + 64'd999_999_999) / 64'd1_000_000_000);
   endfunction

endpackage

// File: rtl/ws2812_edge_sync.sv
// Two-flop synchronizer for the asynchronous data line with rise/fall detect
// on the synchronized value.
module ws2812_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic din_s,
   output logic rise,
   output logic fall
);

   logic meta;
   logic din_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta  <= 1'b0;
         din_s <= 1'b0;
         din_d <= 1'b0;
      end else begin
         meta  <= din;
         din_s <= meta;
         din_d <= din_s;
      end
   end

   assign rise = din_s & ~din_d;
   assign fall = ~din_s & din_d;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 receiver: classifies high pulses by width, assembles 24-bit GRB words,
// and flags latch gaps and timing errors.
module ws2812_rx_decoder
   import ws2812_pkg::*;
#(
   parameter int MIN_HIGH   = 5,
   parameter int BIT_THRESH = 30,
   parameter int MAX_HIGH   = 100,
   parameter int RESET_CYC  = 2500,
   parameter int IDX_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   output logic [PIX_W-1:0] pix_data,
   output logic             pix_valid,
   output logic [IDX_W-1:0] pix_idx,
   output logic             frame_done,
   output logic             err
);

   localparam int CW  = $clog2(((RESET_CYC > MAX_HIGH) ? RESET_CYC : MAX_HIGH) + 1);
   localparam int BCW = $clog2(PIX_W);

   localparam logic [CW-1:0]  RST_C    = CW'(RESET_CYC);
   localparam logic [CW-1:0]  MINH_C   = CW'(MIN_HIGH);
   localparam logic [CW-1:0]  MAXH_C   = CW'(MAX_HIGH);
   localparam logic [CW-1:0]  THRESH_C = CW'(BIT_THRESH);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(PIX_W - 1);

   logic din_s, rise, fall;

   ws2812_edge_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .din_s (din_s),
      .rise  (rise),
      .fall  (fall)
   );

   dec_state_e       state, state_n;
   logic [CW-1:0]    cnt, cnt_n, cnt_inc;
   logic [BCW-1:0]   bit_cnt, bit_cnt_n;
   logic [PIX_W-2:0] shreg, shreg_n;
   logic [IDX_W-1:0] pix_cnt, pix_cnt_n;
   logic             any_pix, any_pix_n;
   logic [PIX_W-1:0] pix_data_n;
   logic [IDX_W-1:0] pix_idx_n;
   logic             pix_valid_n, frame_done_n, err_n;
   logic             bit_val;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= SYNC;
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         pix_cnt    <= '0;
         any_pix    <= 1'b0;
         pix_data   <= '0;
         pix_idx    <= '0;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         pix_cnt    <= pix_cnt_n;
         any_pix    <= any_pix_n;
         pix_data   <= pix_data_n;
         pix_idx    <= pix_idx_n;
         pix_valid  <= pix_valid_n;
         frame_done <= frame_done_n;
         err        <= err_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      bit_cnt_n    = bit_cnt;
      shreg_n      = shreg;
      pix_cnt_n    = pix_cnt;
      any_pix_n    = any_pix;
      pix_data_n   = pix_data;
      pix_idx_n    = pix_idx;
      pix_valid_n  = 1'b0;
      frame_done_n = 1'b0;
      err_n        = 1'b0;
      cnt_inc      = cnt + 1'b1;
      bit_val      = (cnt >= THRESH_C);

      case (state)
         SYNC: begin
            if (din_s) begin
               cnt_n = '0;
            end else if (cnt_inc == RST_C) begin
               // Enter LOW already saturated so this gap is not reported again.
               state_n   = LOW;
               cnt_n     = RST_C;
               bit_cnt_n = '0;
               pix_cnt_n = '0;
               any_pix_n = 1'b0;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         LOW: begin
            if (rise) begin
               state_n = HIGH;
               cnt_n   = CW'(1);
            end else if (cnt != RST_C) begin
               cnt_n = cnt_inc;
               if (cnt_inc == RST_C) begin
                  if (bit_cnt != '0)
                     err_n = 1'b1;
                  else if (any_pix)
                     frame_done_n = 1'b1;
                  bit_cnt_n = '0;
                  pix_cnt_n = '0;
                  any_pix_n = 1'b0;
               end
            end
         end
         HIGH: begin
            if (!fall) begin
               if (cnt >= MAXH_C) begin
                  err_n   = 1'b1;
                  state_n = SYNC;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end else if (cnt < MINH_C) begin
               err_n   = 1'b1;
               state_n = SYNC;
               cnt_n   = '0;
            end else begin
               state_n = LOW;
               cnt_n   = CW'(1);
               shreg_n = {shreg[PIX_W-3:0], bit_val};
               if (bit_cnt == LAST_BIT) begin
                  pix_data_n  = {shreg, bit_val};
                  pix_idx_n   = pix_cnt;
                  pix_valid_n = 1'b1;
                  bit_cnt_n   = '0;
                  pix_cnt_n   = pix_cnt + 1'b1;
                  any_pix_n   = 1'b1;
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_n = SYNC;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: width-boundary table plus hand-built
// frame, partial-pixel, startup and mid-frame reset sequences.
module tb_ws2812_rx_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        din = 1'b0;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic [15:0] pix_idx;
   logic        frame_done;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;
   int n_fd, n_err, n_multi;
   logic [23:0] q_data[$];
   logic [15:0] q_idx[$];

   typedef struct {
      int          hw;
      int          exp_err;
      int          exp_pix;
      logic [23:0] exp_data;
   } wvec_t;

   wvec_t wtab[6];

   always #10 clk = ~clk;

   ws2812_rx_decoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_idx    (pix_idx),
      .frame_done (frame_done),
      .err        (err)
   );

   // Strobe monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (pix_valid) begin
         q_data.push_back(pix_data);
         q_idx.push_back(pix_idx);
      end
      if (frame_done) n_fd++;
      if (err) n_err++;
      if (int'(pix_valid) + int'(frame_done) + int'(err) > 1) n_multi++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n, input logic v);
      repeat (n) begin
         @(negedge clk);
         din = v;
      end
   endtask

   task automatic send_bit(input int hw, input int lw);
      idle(hw, 1'b1);
      idle(lw, 1'b0);
   endtask

   task automatic send_pix(input logic [23:0] d);
      for (int i = 23; i >= 0; i--) begin
         if (d[i]) send_bit(40, 22);
         else      send_bit(20, 42);
      end
   endtask

   task automatic clear_mon();
      q_data.delete();
      q_idx.delete();
      n_fd    = 0;
      n_err   = 0;
      n_multi = 0;
   endtask

   function automatic logic [23:0] get_data(input int i);
      return (q_data.size() > i) ? q_data[i] : 24'hxxxxxx;
   endfunction

   function automatic logic [15:0] get_idx(input int i);
      return (q_idx.size() > i) ? q_idx[i] : 16'hxxxx;
   endfunction

   task automatic check_frame(input string tag, input int exp_pix, input int exp_fd, input int exp_err);
      check({tag, "_pix_count"}, q_data.size(), exp_pix);
      check({tag, "_frame_done"}, n_fd, exp_fd);
      check({tag, "_err"}, n_err, exp_err);
      check({tag, "_one_strobe"}, n_multi, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      wtab[0] = '{hw: 4,   exp_err: 1, exp_pix: 0, exp_data: 24'hxxxxxx};
      wtab[1] = '{hw: 5,   exp_err: 0, exp_pix: 1, exp_data: 24'h000000};
      wtab[2] = '{hw: 29,  exp_err: 0, exp_pix: 1, exp_data: 24'h000000};
      wtab[3] = '{hw: 30,  exp_err: 0, exp_pix: 1, exp_data: 24'h800000};
      wtab[4] = '{hw: 100, exp_err: 0, exp_pix: 1, exp_data: 24'h800000};
      wtab[5] = '{hw: 101, exp_err: 1, exp_pix: 0, exp_data: 24'hxxxxxx};

      clear_mon();
      idle(3, 1'b0);
      check("reset_pix_data", pix_data, 0);
      check("reset_pix_idx", pix_idx, 0);
      check("reset_strobes", {pix_valid, frame_done, err}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Power-up gap, single pixel, latch gap.
      idle(2510, 1'b0);
      send_pix(24'h00FF00);
      idle(2600, 1'b0);
      check_frame("single", 1, 1, 0);
      check("single_data", get_data(0), 24'h00FF00);
      check("single_idx", get_idx(0), 0);
      check("single_hold", pix_data, 24'h00FF00);

      // Three pixels back to back.
      clear_mon();
      send_pix(24'h123456);
      send_pix(24'hABCDEF);
      send_pix(24'h000001);
      idle(2600, 1'b0);
      check_frame("triple", 3, 1, 0);
      check("triple_d0", get_data(0), 24'h123456);
      check("triple_d1", get_data(1), 24'hABCDEF);
      check("triple_d2", get_data(2), 24'h000001);
      check("triple_i0", get_idx(0), 0);
      check("triple_i1", get_idx(1), 1);
      check("triple_i2", get_idx(2), 2);
      check("triple_hold_idx", pix_idx, 2);

      // High-width boundaries: first bit of the frame carries the width under test.
      for (int i = 0; i < 6; i++) begin
         clear_mon();
         send_bit(wtab[i].hw, (wtab[i].hw < 42) ? 62 - wtab[i].hw : 20);
         repeat (23) send_bit(20, 42);
         idle(2600, 1'b0);
         check($sformatf("w%0d_err", wtab[i].hw), n_err, wtab[i].exp_err);
         check($sformatf("w%0d_pix", wtab[i].hw), q_data.size(), wtab[i].exp_pix);
         check($sformatf("w%0d_fd", wtab[i].hw), n_fd, wtab[i].exp_pix);
         check($sformatf("w%0d_data", wtab[i].hw), get_data(0), wtab[i].exp_data);
      end

      // Partial pixel then gap, followed by a clean frame.
      clear_mon();
      repeat (10) send_bit(40, 22);
      idle(2600, 1'b0);
      check_frame("partial", 0, 0, 1);
      clear_mon();
      send_pix(24'hA5A5A5);
      idle(2600, 1'b0);
      check_frame("after_partial", 1, 1, 0);
      check("after_partial_data", get_data(0), 24'hA5A5A5);
      check("after_partial_idx", get_idx(0), 0);

      // Line high at reset release, stream with no leading gap is ignored.
      clear_mon();
      @(negedge clk);
      din   = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(50, 1'b1);
      send_pix(24'h0F0F0F);
      idle(2600, 1'b0);
      send_pix(24'h111111);
      idle(2600, 1'b0);
      check_frame("startup_high", 1, 1, 0);
      check("startup_high_data", get_data(0), 24'h111111);
      check("startup_high_idx", get_idx(0), 0);

      // One-cycle reset after bit 12, then the rest of the stream without a gap.
      clear_mon();
      send_bit(40, 22);
      repeat (11) send_bit(20, 42);
      @(negedge clk);
      din   = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midreset_pix_data", pix_data, 0);
      check("midreset_pix_idx", pix_idx, 0);
      check("midreset_strobes", {pix_valid, frame_done, err}, 0);
      repeat (12) send_bit(40, 22);
      send_pix(24'hC3C3C3);
      idle(2600, 1'b0);
      send_pix(24'h5A5A5A);
      idle(2600, 1'b0);
      check_frame("midreset", 1, 1, 0);
      check("midreset_data", get_data(0), 24'h5A5A5A);
      check("midreset_idx", get_idx(0), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ws2812_rx_decoder.md
# ws2812_rx_decoder

Single-wire WS2812 stream decoder: samples the NRZ LED data line, classifies each high pulse as a 0 or 1 bit by width, assembles 24-bit GRB pixel words, and reports frame latch (reset gap) and timing errors. It is the receiving end of the `data` line driven by the WS2812_Protocol transmit path. It serves as a loopback checker on the board and as the input stage of a daisy-chain/pass-through design.

## Interface
Parameters:
- `MIN_HIGH`, 5: minimum legal high width in `clk` cycles (100 ns @ 50 MHz); shorter is a glitch error.
- `BIT_THRESH`, 30: high width ≥ this decodes as 1, else 0 (0.6 µs).
- `MAX_HIGH`, 100: high width > this is a stuck-high error (2 µs).
- `RESET_CYC`, 2500: consecutive low cycles forming a latch/reset gap (50 µs).
- `IDX_W`, 16: width of the pixel index.

Ports:
- `clk`  in  1: system clock (50 MHz nominal).
- `rst_n`  in  1: **one clock; reset is synchronous and active-low**.
- `din`  in  1: asynchronous WS2812 data line.
- `pix_data`  out  24: last decoded pixel, GRB, MSB first on the wire (G[7] = bit 23).
- `pix_valid`  out  1: one-cycle strobe; `pix_data`/`pix_idx` valid. No backpressure.
- `pix_idx`  out  IDX_W: index of the strobed pixel within the current frame, 0-based.
- `frame_done`  out  1: one-cycle strobe at a latch gap ending a frame with ≥1 pixel.
- `err`  out  1: one-cycle strobe on glitch, stuck-high, or partial-pixel error.

## Operation
- `din` passes through a 2-FF synchronizer; edges are detected on the synchronized value `din_s`.
- States:
  - SYNC: count consecutive low `din_s` cycles. A high restarts the count. Reaching `RESET_CYC` → LOW with the frame cleared. Entered on reset and after any error, so decoding never starts mid-frame.
  - LOW: count low cycles. Rising edge → HIGH with width counter = 1. Reaching `RESET_CYC`, once per gap: if `bit_cnt` ≠ 0, pulse `err` and discard the partial pixel. Else if pixels > 0, pulse `frame_done`. Then clear `bit_cnt` and the pixel counter. The counter saturates at `RESET_CYC`.
  - HIGH: count width w.
    - Width exceeds `MAX_HIGH` → `err`, go to SYNC.
    - Falling edge with w < `MIN_HIGH` → `err`, go to SYNC.
    - Any other falling edge: bit = (w ≥ `BIT_THRESH`). Shift left into the 24-bit shifter, increment `bit_cnt`, go to LOW with low count = 1.
- On the 24th bit: register the shifter into `pix_data`, drive `pix_idx` = pixel counter, pulse `pix_valid`, clear `bit_cnt`, and increment the pixel counter.
- The pixel counter wraps modulo 2^IDX_W with no error.
- Low time between bits is not checked against the bit period. Any low time shorter than `RESET_CYC` is a legal gap.
- Counters are $clog2(max(RESET_CYC, MAX_HIGH)+1) bits wide.
- Width comparisons are unsigned against the parameters.

## Timing
- Reset (`rst_n` = 0 at a `clk` edge): state SYNC, all counters 0, `pix_data` = 0, `pix_idx` = 0, `pix_valid` = `frame_done` = `err` = 0, synchronizer flops = 0.
  - Asserting `rst_n` mid-pixel or mid-frame discards all partial state, with no strobes.
- Latency: `pix_valid` rises 3 `clk` cycles after the first cycle `din` is sampled low at the end of bit 23 (2 synchronizer stages + 1 output register).
- `frame_done` and `err` pulse in the cycle after the qualifying count is reached.
- Strobes are exactly 1 cycle wide. At most one of `pix_valid`/`frame_done`/`err` is high per cycle.
- `pix_data` and `pix_idx` hold their values between strobes.
- Width boundaries:
  - w = `MIN_HIGH` is legal.
  - w = `BIT_THRESH` decodes as 1.
  - w = `MAX_HIGH` is legal.
  - w = `MAX_HIGH` + 1 is an error.
- Widths are measured on `din_s`, so the ±1-cycle synchronizer uncertainty is accepted.

## Structure
- Shared package `ws2812_pkg`:
  - nominal timing constants in ns: T0H 400, T1H 800, TBIT 1250, TRESET 50000;
  - a `cycles(ns, CLK_HZ)` function;
  - `PIX_W` = 24;
  - the decoder state enum {SYNC, LOW, HIGH}.
- The transmitter uses the same package.
- Sub-module `ws2812_edge_sync`: 2-FF synchronizer plus rise/fall detect. Outputs `din_s`, `rise`, `fall`; synchronous active-low reset.
- Everything else stays in one FSM plus datapath file.

## Test plan
- Power-up with `din` low for 2500 cycles, then 24 bits of 0x00FF00 (T0H 20 / T1H 40 cycles, period 62), then 2500 cycles low → one `pix_valid` with `pix_data` = 0x00FF00, `pix_idx` = 0, then one `frame_done`.
- Three pixels 0x123456, 0xABCDEF, 0x000001 back-to-back, then a gap → strobes with idx 0, 1, 2 and matching data; `frame_done` once; no `err`.
- High widths 4, 5, 29, 30, 100, 101 in separate frames → 4: `err`; 5: bit 0; 29: bit 0; 30: bit 1; 100: bit 1; 101: `err` with return to SYNC.
- 10 bits, then a 2500-cycle gap → `err` pulse, no `pix_valid`, no `frame_done`. The next frame decodes with idx 0.
- `din` high at reset release, then the stream starts without a preceding gap → no decode until a 2500-cycle low gap is seen. Bits before it are ignored.
- `rst_n` pulsed low for 1 cycle after bit 12 → all outputs 0, no strobes. Decoding resumes only after a full gap.
